// File: rtl/ddr_rb_capture.sv
`timescale 1ns/1ps
// ddr_rb_capture: DDR read-path ring-buffer capture.
// Every strobe level change while a capture window is open is one beat; beats
// go into a DEPTH-entry circular memory and each BURST_LEN-beat burst is also
// packed into burst_data (beat 0 in the LSBs). Strobe edges outside a window
// raise the sticky stray flag.
// Optional statistics counters: define DDR_RB_STATS_EN.
module ddr_rb_capture #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 8,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        listen,
  input  logic                        strobe,
  input  logic [DATA_W-1:0]           din,
  input  logic                        rd_en,
  input  logic [PTR_W-1:0]            rd_ptr,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_valid,
  output logic                        burst_done,
  output logic [DATA_W*BURST_LEN-1:0] burst_data,
  output logic [PTR_W-1:0]            wr_ptr,
  output logic                        stray,
  output logic                        abort,
  output logic [15:0]                 burst_count,
  output logic [15:0]                 stray_count
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                             state_q;
  logic                               strobe_q;
  logic                               listen_q;
  logic [BEAT_W-1:0]                  beat_q;
  logic [PTR_W-1:0]                   wr_ptr_q;
  logic [PTR_W-1:0]                   start_q;
  logic [BURST_LEN-1:0][DATA_W-1:0]   shadow_q;
  logic [DATA_W*BURST_LEN-1:0]        burst_data_q;
  logic                               burst_done_q;
  logic                               abort_q;
  logic                               stray_q;
  logic [DATA_W-1:0]                  dout_q;
  logic                               dout_valid_q;
  logic [DATA_W-1:0]                  mem [DEPTH];

  logic strobe_edge_d;
  logic wr_en_d;
  logic last_beat_d;
  logic stray_edge_d;

  // Edge detection and per-cycle qualifiers derived from the current state
  always_comb begin
    strobe_edge_d = strobe ^ strobe_q;
    wr_en_d       = strobe_edge_d && !reset && (state_q != S_IDLE);
    last_beat_d   = (state_q == S_CAPTURE) && strobe_edge_d &&
                    (beat_q == BEAT_W'(BURST_LEN - 1));
    stray_edge_d  = strobe_edge_d && (state_q == S_IDLE);
  end

  // Capture FSM with registered pulses, pointer, shadow and burst register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      strobe_q     <= 1'b0;
      listen_q     <= 1'b0;
      beat_q       <= '0;
      wr_ptr_q     <= '0;
      start_q      <= '0;
      shadow_q     <= '0;
      burst_data_q <= '0;
      burst_done_q <= 1'b0;
      abort_q      <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      strobe_q     <= strobe;
      listen_q     <= listen;
      burst_done_q <= 1'b0;
      abort_q      <= 1'b0;

      // A stray edge in the same cycle as a listen rise keeps the flag set
      if (stray_edge_d)
        stray_q <= 1'b1;
      else if (listen && !listen_q)
        stray_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (listen)
            state_q <= S_ARMED;
        end
        S_ARMED: begin
          // An edge wins over listen falling: the beat is taken and any
          // abort is decided from CAPTURE on the following cycle.
          if (strobe_edge_d) begin
            shadow_q[0] <= din;
            start_q     <= wr_ptr_q;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
            beat_q      <= BEAT_W'(1);
            state_q     <= S_CAPTURE;
          end else if (!listen) begin
            state_q <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (strobe_edge_d) begin
            shadow_q[beat_q] <= din;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            if (last_beat_d) begin
              // Last beat goes straight from din; the shadow slot is not yet updated
              burst_data_q <= {din, shadow_q[BURST_LEN-2:0]};
              burst_done_q <= 1'b1;
              beat_q       <= '0;
              state_q      <= listen ? S_ARMED : S_IDLE;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end else if (!listen) begin
            abort_q  <= 1'b1;
            wr_ptr_q <= start_q;
            beat_q   <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ring memory write port (contents are deliberately not reset)
  always_ff @(posedge clk) begin
    if (wr_en_d)
      mem[wr_ptr_q] <= din;
  end

  // Registered readback; a same-address write this cycle returns old data
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_en;
      if (rd_en)
        dout_q <= mem[rd_ptr];
    end
  end

`ifdef DDR_RB_STATS_EN
  logic [15:0] burst_count_q;
  logic [15:0] stray_count_q;

  // Saturating statistics counters, updated alongside the events they count
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_count_q <= '0;
      stray_count_q <= '0;
    end else begin
      if (last_beat_d && (burst_count_q != '1))
        burst_count_q <= burst_count_q + 16'd1;
      if (stray_edge_d && (stray_count_q != '1))
        stray_count_q <= stray_count_q + 16'd1;
    end
  end

  assign burst_count = burst_count_q;
  assign stray_count = stray_count_q;
`else
  assign burst_count = '0;
  assign stray_count = '0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign burst_done = burst_done_q;
  assign burst_data = burst_data_q;
  assign wr_ptr     = wr_ptr_q;
  assign stray      = stray_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_ddr_rb_capture.sv
`timescale 1ns/1ps
// tb_ddr_rb_capture: directed vector table, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_ddr_rb_capture;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int BL = 8;
  localparam int PW = 4;

  logic              clk;
  logic              reset;
  logic              listen;
  logic              strobe;
  logic [DW-1:0]     din;
  logic              rd_en;
  logic [PW-1:0]     rd_ptr;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              burst_done;
  logic [DW*BL-1:0]  burst_data;
  logic [PW-1:0]     wr_ptr;
  logic              stray;
  logic              abort;
  logic [15:0]       burst_count;
  logic [15:0]       stray_count;

  ddr_rb_capture #(.DATA_W(DW), .DEPTH(DP), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .listen(listen), .strobe(strobe), .din(din),
    .rd_en(rd_en), .rd_ptr(rd_ptr), .dout(dout), .dout_valid(dout_valid),
    .burst_done(burst_done), .burst_data(burst_data), .wr_ptr(wr_ptr),
    .stray(stray), .abort(abort), .burst_count(burst_count),
    .stray_count(stray_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b1; listen = 1'b0; strobe = 1'b0; rd_en = 1'b0; rd_ptr = '0; din = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          lis;
    logic          tog;
    logic [15:0]   d;
    logic          rde;
    logic [3:0]    rdp;
    logic          e_done;
    logic          e_abort;
    logic          e_stray;
    logic          e_dv;
    logic [3:0]    e_wp;
    logic [15:0]   e_dout;
  } vec_t;

  function automatic vec_t mk(input logic lis, input logic tog, input logic [15:0] d,
                              input logic rde, input logic [3:0] rdp, input logic e_done,
                              input logic e_abort, input logic e_stray, input logic e_dv,
                              input logic [3:0] e_wp, input logic [15:0] e_dout);
    vec_t v;
    v.lis = lis; v.tog = tog; v.d = d; v.rde = rde; v.rdp = rdp;
    v.e_done = e_done; v.e_abort = e_abort; v.e_stray = e_stray; v.e_dv = e_dv;
    v.e_wp = e_wp; v.e_dout = e_dout;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [15:0]  m_mem [DP];
  bit           m_known [DP];
  logic [15:0]  cur [$];
  int           m_wp, m_start;
  bit           m_win;
  logic [127:0] m_bd;
  bit           m_done, m_abort, m_stray, m_dv, m_dknown;
  logic [15:0]  m_dout;
  int           m_bc, m_sc;
  logic         m_prev_strobe, m_prev_listen;

  task automatic model_write(input logic [15:0] d);
    m_mem[m_wp]   = d;
    m_known[m_wp] = 1'b1;
    m_wp          = (m_wp + 1) % DP;
  endtask

  task automatic model_step(input logic rst, input logic lis, input logic stb,
                            input logic [15:0] d, input logic rde, input logic [3:0] rdp);
    bit e;
    if (rst) begin
      cur.delete();
      m_wp = 0; m_start = 0; m_win = 0; m_bd = '0;
      m_done = 0; m_abort = 0; m_stray = 0; m_dv = 0; m_dout = '0; m_dknown = 1;
      m_bc = 0; m_sc = 0; m_prev_strobe = 1'b0; m_prev_listen = 1'b0;
      return;
    end
    e = (stb != m_prev_strobe);
    m_done = 0; m_abort = 0;
    if (rde) begin
      m_dout = m_mem[rdp]; m_dknown = m_known[rdp]; m_dv = 1;
    end else begin
      m_dv = 0;
    end
    if (e && !m_win && cur.size() == 0) begin
      m_stray = 1;
      if (m_sc != 16'hFFFF) m_sc++;
    end else if (lis && !m_prev_listen) begin
      m_stray = 0;
    end
    if (cur.size() != 0) begin
      if (e) begin
        model_write(d);
        cur.push_back(d);
        if (cur.size() == BL) begin
          for (int k = 0; k < BL; k++) m_bd[16*k +: 16] = cur[k];
          m_done = 1;
          if (m_bc != 16'hFFFF) m_bc++;
          cur.delete();
          m_win = lis;
        end
      end else if (!lis) begin
        m_abort = 1; m_wp = m_start; cur.delete(); m_win = 0;
      end
    end else if (m_win) begin
      if (e) begin
        m_start = m_wp;
        model_write(d);
        cur.push_back(d);
      end else if (!lis) begin
        m_win = 0;
      end
    end else if (lis) begin
      m_win = 1;
    end
    m_prev_strobe = stb;
    m_prev_listen = lis;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tv [25];
    logic [127:0] bd_exp;
    int           n_done, first_k, second_k;
    logic [15:0]  exp_bc, exp_sc;

    for (int i = 0; i < DP; i++) m_known[i] = 1'b0;

    // Table: one burst, readback of it, truncated burst, stray edges, listen rise
    tv[0] = mk(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 4'd0, 16'h0);
    for (int i = 1; i <= 8; i++)
      tv[i] = mk(1, 1, 16'(16'h1000 + i - 1), 0, 0, (i == 8), 0, 0, 0, 4'(i), 16'h0);
    for (int i = 9; i <= 16; i++)
      tv[i] = mk(1, 0, 16'h0, 1, 4'(i - 9), 0, 0, 0, 1, 4'd8, 16'(16'h1000 + i - 9));
    for (int i = 17; i <= 19; i++)
      tv[i] = mk(1, 1, 16'(16'h00A0 + i - 17), 0, 0, 0, 0, 0, 0, 4'(i - 8), 16'h1007);
    tv[20] = mk(0, 0, 16'h0, 0, 0, 0, 1, 0, 0, 4'd8, 16'h1007);
    tv[21] = mk(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 4'd8, 16'h1007);
    tv[22] = mk(0, 1, 16'h0, 0, 0, 0, 0, 1, 0, 4'd8, 16'h1007);
    tv[23] = mk(0, 1, 16'h0, 0, 0, 0, 0, 1, 0, 4'd8, 16'h1007);
    tv[24] = mk(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 4'd8, 16'h1007);

    for (int k = 0; k < BL; k++) bd_exp[16*k +: 16] = 16'(16'h1000 + k);

    reset_dut();
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_burst_data", burst_data, 0);
    chk("rst_flags", {burst_done, abort, stray, dout_valid}, 0);
    chk("rst_dout", dout, 0);
    chk("rst_counts", {burst_count, stray_count}, 0);

    for (int i = 0; i < 25; i++) begin
      listen = tv[i].lis;
      if (tv[i].tog) strobe = ~strobe;
      din    = tv[i].d;
      rd_en  = tv[i].rde;
      rd_ptr = tv[i].rdp;
      cyc();
      chk($sformatf("tv%0d_done", i),   burst_done, tv[i].e_done);
      chk($sformatf("tv%0d_abort", i),  abort,      tv[i].e_abort);
      chk($sformatf("tv%0d_stray", i),  stray,      tv[i].e_stray);
      chk($sformatf("tv%0d_wr_ptr", i), wr_ptr,     tv[i].e_wp);
      chk($sformatf("tv%0d_dvalid", i), dout_valid, tv[i].e_dv);
      if (tv[i].lis && i > 8)
        chk($sformatf("tv%0d_dout", i), dout, tv[i].e_dout);
      if (i == 8 || i == 20)
        chk($sformatf("tv%0d_burst_data", i), burst_data, bd_exp);
    end
`ifdef DDR_RB_STATS_EN
    exp_bc = 16'd1; exp_sc = 16'd2;
`else
    exp_bc = 16'd0; exp_sc = 16'd0;
`endif
    chk("tbl_burst_count", burst_count, exp_bc);
    chk("tbl_stray_count", stray_count, exp_sc);

    // Two back-to-back bursts with no gap cycle
    reset_dut();
    listen = 1'b1;
    cyc();
    n_done = 0; first_k = -1; second_k = -1;
    for (int k = 0; k < 2 * BL; k++) begin
      strobe = ~strobe;
      din    = 16'(16'hB000 + k);
      cyc();
      if (burst_done === 1'b1) begin
        n_done++;
        if (first_k < 0) first_k = k; else second_k = k;
      end
    end
    chk("b2b_pulses", n_done, 2);
    chk("b2b_first", first_k, 7);
    chk("b2b_gap", second_k - first_k, 8);
    chk("b2b_wr_ptr", wr_ptr, 0);
    for (int k = 0; k < BL; k++) bd_exp[16*k +: 16] = 16'(16'hB008 + k);
    chk("b2b_burst_data", burst_data, bd_exp);
`ifdef DDR_RB_STATS_EN
    exp_bc = 16'd2;
`else
    exp_bc = 16'd0;
`endif
    chk("b2b_burst_count", burst_count, exp_bc);
    listen = 1'b0;
    cyc();
    chk("b2b_done_clear", burst_done, 0);

    // Reset in the middle of a burst, then a clean burst from beat 0
    reset_dut();
    listen = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      strobe = ~strobe; din = 16'(16'hC000 + k);
      cyc();
    end
    reset = 1'b1; strobe = 1'b0; listen = 1'b0;
    cyc();
    chk("midrst_wr_ptr", wr_ptr, 0);
    chk("midrst_burst_data", burst_data, 0);
    chk("midrst_flags", {burst_done, abort, stray, dout_valid}, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_counts", {burst_count, stray_count}, 0);
    reset = 1'b0; listen = 1'b1;
    cyc();
    for (int k = 0; k < BL; k++) begin
      strobe = ~strobe; din = 16'(16'hD000 + k);
      cyc();
      if (k < BL - 1) chk($sformatf("midrst_nodone%0d", k), burst_done, 0);
    end
    for (int k = 0; k < BL; k++) bd_exp[16*k +: 16] = 16'(16'hD000 + k);
    chk("midrst_done", burst_done, 1);
    chk("midrst_burst_data2", burst_data, bd_exp);
    chk("midrst_wr_ptr2", wr_ptr, 8);

    // Randomized run against the reference model
    reset_dut();
    model_step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) listen = ~listen;
      if ($urandom_range(0, 3) != 0) strobe = ~strobe;
      din    = 16'($urandom);
      rd_en  = $urandom_range(0, 1) == 1;
      rd_ptr = 4'($urandom_range(0, DP - 1));
      model_step(reset, listen, strobe, din, rd_en, rd_ptr);
      cyc();
      chk("rnd_done",   burst_done, m_done);
      chk("rnd_abort",  abort,      m_abort);
      chk("rnd_stray",  stray,      m_stray);
      chk("rnd_wr_ptr", wr_ptr,     m_wp);
      chk("rnd_dvalid", dout_valid, m_dv);
      chk("rnd_burst_data", burst_data, m_bd);
      if (m_dknown) chk("rnd_dout", dout, m_dout);
`ifdef DDR_RB_STATS_EN
      chk("rnd_burst_count", burst_count, m_bc);
      chk("rnd_stray_count", stray_count, m_sc);
`else
      chk("rnd_counts_zero", {burst_count, stray_count}, 0);
`endif
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_rb_capture.md
Name: ddr_rb_capture

Overview:
Synthesizable, parametrised ring-buffer capture block for the DDR controller read path. It samples `din` on every strobe transition (both edges, DDR style) while `listen` is high and packs each `BURST_LEN`-beat burst into a wide register. Beats are stored in a `DEPTH`-entry circular memory that supports random-access readback. Protocol violations are flagged in hardware rather than left to testbench messages.

Parameters:
- DATA_W, 16, width of one beat.
- DEPTH, 8, ring entries; power of 2; must be a multiple of BURST_LEN.
- BURST_LEN, 8, beats per burst; must be 2 or more.
- PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- listen  in  1  capture enable from the controller
- strobe  in  1  data strobe; every level change is one beat
- din  in  DATA_W  beat data, valid in the cycle the strobe change is detected
- rd_en  in  1  readback request
- rd_ptr  in  PTR_W  readback address
- dout  out  DATA_W  readback data
- dout_valid  out  1  pulse: dout valid
- burst_done  out  1  pulse: burst_data updated
- burst_data  out  DATA_W*BURST_LEN  last complete burst; beat 0 in the LSBs
- wr_ptr  out  PTR_W  next ring write address
- stray  out  1  sticky: strobe edge seen outside a capture window
- abort  out  1  pulse: burst truncated by `listen` falling
- burst_count  out  16  completed bursts (optional feature)
- stray_count  out  16  stray edges (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, strobe_q 0, beat counter 0. Memory contents are not reset.
- Edge detect: strobe_q is a register copy of strobe; edge = strobe ^ strobe_q. Sampling is in the clk domain only.
- State IDLE:
  - listen=1 -> ARMED.
  - An edge in IDLE sets stray (no write).
- State ARMED:
  - edge -> write din to mem[wr_ptr]; wr_ptr+1 mod DEPTH; latch burst start = old wr_ptr; beat=1; go to CAPTURE.
  - listen=0 -> IDLE.
- State CAPTURE:
  - Each edge writes mem[wr_ptr] and the shadow word[beat]; wr_ptr and beat increment.
  - On the edge writing beat BURST_LEN-1: next cycle burst_data = shadow, burst_done=1 for 1 cycle, beat=0.
  - After the last beat: state -> ARMED if listen=1, else IDLE. Back-to-back bursts need no gap cycle.
  - listen=0 mid-burst with no edge in that cycle: abort=1 for 1 cycle; wr_ptr rewinds to burst start; burst_data unchanged; -> IDLE.
  - listen=0 in the same cycle as an edge: the edge is captured first, and abort/rewind is evaluated on the next cycle.
- Readback:
  - rd_en=1 -> dout=mem[rd_ptr] and dout_valid=1 on the next cycle.
  - Without rd_en, dout holds its value and dout_valid=0.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
- Wrap-around: wr_ptr wraps DEPTH-1 -> 0 silently. Unread data is overwritten; there is no full flag.
- Clearing stray: stray clears only on reset or on the rising edge of listen.

Optional Feature:
- Macro: DDR_RB_STATS_EN.
- Defined:
  - burst_count increments on each burst_done.
  - stray_count increments on each stray edge.
  - Both counters are saturating at 16'hFFFF and reset to 0.
- Undefined: both counter ports exist but are tied to 0, and no counter logic is synthesised.

Test Plan:
- Reset, listen=1, 8 strobe toggles with din=16'h1000..16'h1007 -> one burst_done pulse 1 cycle after beat 7; burst_data=128'h1007_1006_…_1000; wr_ptr=0 (wrapped).
- After that burst, rd_en with rd_ptr=0..7 -> dout=16'h1000..16'h1007, each 1 cycle after its request, with dout_valid high.
- listen=1, 3 toggles (din A0,A1,A2), then listen=0 -> abort pulse; wr_ptr returns to its pre-burst value; burst_data unchanged; no burst_done.
- Strobe toggles with listen=0 -> stray=1 and no write; stray_count=number of toggles with macro defined, 0 without; raising listen clears stray.
- Two bursts of 8 toggles back to back, no gap (DEPTH=16) -> two burst_done pulses 8 cycles apart; wr_ptr=0; burst_count=2 with the macro.
- Reset asserted mid-burst at beat 4 -> all outputs 0 next cycle; subsequent full burst is captured correctly from beat 0.
